multi_cycle_controller: RTL
===========================

# multi_cycle_controller

Multi-cycle CPU control unit that sequences every instruction through IF/ID/EXE/MEM/WB and drives the write enables and muxes of the PC, InstructionMemory, IR, register file, ALU and data memory. It sits beside the datapath, reads the 6-bit opcode from the IR plus the ALU zero flag, and holds a 3-bit state register. All datapath registers update on the same CLK edge that advances the controller state.

## Interface
Parameters: none. Widths are fixed by the ISA.
- CLK  in  1  system clock; all state changes occur on the rising edge
- Reset  in  1  synchronous, active-low reset; one clock; sampled on the rising CLK edge
- op  in  6  opcode IR[31:26]
- zero  in  1  ALU zero flag
- PCWre, IRWre, InsMemRW, RegWre, mRD, mWR  out  1 each  write/read enables
- ALUSrcB  out  1  0 = register rt, 1 = extended immediate
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- DBDataSrc  out  1  0 = ALU result, 1 = data memory
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB data
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = {PC+4[31:28], addr, 00}
- ALUOp  out  3  000 ADD, 001 SUB, 010 SLT, 011 OR, 100 AND
- state  out  3  current state
- halted  out  1  halt reached

## Operation
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is illegal.
- State encodings: IF 000, ID 001, EXE_MEM 010, MEM 011, WB_LW 100, EXE_BR 101, EXE_ALU 110, WB_ALU 111.
- Transitions:
  - IF→ID.
  - ID→IF for j/jr/jal/illegal.
  - ID→ID for halt, with halted latched to 1.
  - ID→EXE_BR for beq/bne.
  - ID→EXE_MEM for lw/sw.
  - ID→EXE_ALU otherwise.
  - EXE_ALU→WB_ALU→IF.
  - EXE_BR→IF.
  - EXE_MEM→MEM.
  - MEM→IF for sw; MEM→WB_LW for lw.
  - WB_LW→IF.
- Outputs are combinational from state and op:
  - InsMemRW=IRWre=1 only in IF.
  - PCWre=1 only in an instruction's final state: ID for j/jr/jal/illegal, EXE_BR, WB_ALU, MEM(sw), WB_LW. PCWre is never 1 when halted.
  - PCSrc: 11 for j/jal, 10 for jr, 01 in EXE_BR when taken, else 00. Taken means beq with zero=1 or bne with zero=0.
  - RegWre=1 in WB_ALU, WB_LW, and ID(jal). RegDst: 00 for jal, 10 for R-type, 01 otherwise. WrRegDSrc=0 only for jal. DBDataSrc=1 only for lw.
  - mRD=1 in MEM(lw); mWR=1 in MEM(sw).
  - ALUSrcB=1 for addiu/andi/ori/slti/lw/sw. ExtSel=0 only for andi/ori.
  - ALUOp: SUB for sub/beq/bne; SLT for slt/slti; OR for ori; AND for and/andi; ADD otherwise.
- Illegal opcode: takes 2 cycles, writes nothing except PC+4.

## Timing
- Cycles per instruction: j/jr/jal 2, beq/bne 3, R/I-type ALU 4, sw 4, lw 5.
- Reset low at an edge: state←IF and halted←0. This applies even mid-instruction or while halted; no write from the aborted instruction may follow.
- While Reset is low: PCWre, IRWre, InsMemRW, RegWre, mRD and mWR are forced 0. Every mux select and ALUOp reads 0, state reads 000, and halted reads 0.
- First fetch occurs in the first cycle after Reset returns high.
- halted rises on the edge leaving ID with op=halt and holds until reset. State stays 001.
- op must be stable from the edge ending IF through the last state of the instruction. The controller never samples op in IF.

## Structure
- A shared package holds the opcode constants, state encodings, ALUOp codes, and the PCSrc/RegDst encodings. The datapath muxes and ALU reuse these.
- Optional sub-module `mcc_decode`: purely combinational, (state, op, zero) → control outputs. The top level holds only the state register, the halted flag and the next-state logic.

## Test plan
- Reset held 3 cycles, then released with op=add → state sequence 000,001,110,111,000. RegWre=1 and RegDst=10 only in 111; PCWre=1 only in 111.
- lw (110001) → 000,001,010,011,100,000. mRD=1 in 011; RegWre=1, DBDataSrc=1 and RegDst=01 in 100; ALUSrcB=1 and ExtSel=1 in 010.
- beq with zero=1, then bne with zero=1 → beq: PCSrc=01, PCWre=1 in 101. bne: PCSrc=00, PCWre=1 in 101. Each takes 3 cycles.
- jal → 2 cycles. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- halt → state remains 001, halted=1, PCWre=0 for 20 cycles. Reset pulse → state 000, halted=0.
- Reset asserted during MEM of sw → at that edge mWR is forced 0 and state becomes 000. Illegal op 101010 → 2 cycles, RegWre=0, mWR=0.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared ISA constants for the multi-cycle CPU: opcodes, controller states,
// ALU operation codes and the PC / destination-register mux encodings.
package multi_cycle_controller_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_MEM = 3'b010,
    S_MEM     = 3'b011,
    S_WB_LW   = 3'b100,
    S_EXE_BR  = 3'b101,
    S_EXE_ALU = 3'b110,
    S_WB_ALU  = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic       m_rd;
    logic       m_wr;
    logic       alu_src_b;
    logic       ext_sel;
    logic       db_data_src;
    logic       wr_reg_d_src;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI,
                      OP_SLT, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE,
                      OP_J, OP_JR, OP_JAL, OP_HALT};
  endfunction

  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_SLT};
  endfunction

  // Instructions that finish in ID with only a PC update (illegal ops included).
  function automatic logic ends_in_id(input logic [5:0] op);
    return (op inside {OP_J, OP_JR, OP_JAL}) || !is_legal(op);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: opcode/zero flag in, enables and mux selects out.
// Combinational level signals, no handshake: each value is valid for the cycle it is shown.
interface multi_cycle_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;
  logic       halted;

  modport master (
    input  op, zero,
    output PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, state, halted
  );

  modport slave (
    output op, zero,
    input  PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, state, halted
  );
endinterface

// File: rtl/mcc_decode.sv
// Pure combinational decode of (state, op, zero) into datapath control signals.
module mcc_decode
  import multi_cycle_controller_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  logic taken;
  assign taken = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);

  always_comb begin
    ctrl_o = '0;

    // Enables depend on where the instruction is in its sequence.
    case (state_i)
      S_IF: begin
        ctrl_o.ins_mem_rw = 1'b1;
        ctrl_o.ir_wre     = 1'b1;
      end
      S_ID: begin
        ctrl_o.pc_wre  = ends_in_id(op_i);
        ctrl_o.reg_wre = (op_i == OP_JAL);
      end
      S_EXE_BR: ctrl_o.pc_wre = 1'b1;
      S_MEM: begin
        ctrl_o.m_rd   = (op_i == OP_LW);
        ctrl_o.m_wr   = (op_i == OP_SW);
        ctrl_o.pc_wre = (op_i == OP_SW);
      end
      S_WB_LW, S_WB_ALU: begin
        ctrl_o.pc_wre  = 1'b1;
        ctrl_o.reg_wre = 1'b1;
      end
      default: ;
    endcase

    ctrl_o.alu_src_b    = op_i inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
    ctrl_o.ext_sel      = !(op_i inside {OP_ANDI, OP_ORI});
    ctrl_o.db_data_src  = (op_i == OP_LW);
    ctrl_o.wr_reg_d_src = (op_i != OP_JAL);

    if (op_i == OP_JAL)     ctrl_o.reg_dst = REGDST_RA;
    else if (is_rtype(op_i)) ctrl_o.reg_dst = REGDST_RD;
    else                    ctrl_o.reg_dst = REGDST_RT;

    if (op_i inside {OP_J, OP_JAL})           ctrl_o.pc_src = PCSRC_JUMP;
    else if (op_i == OP_JR)                   ctrl_o.pc_src = PCSRC_REG;
    else if ((state_i == S_EXE_BR) && taken)  ctrl_o.pc_src = PCSRC_BRANCH;
    else                                      ctrl_o.pc_src = PCSRC_SEQ;

    if (op_i inside {OP_SUB, OP_BEQ, OP_BNE})      ctrl_o.alu_op = ALU_SUB;
    else if (op_i inside {OP_SLT, OP_SLTI})        ctrl_o.alu_op = ALU_SLT;
    else if (op_i == OP_ORI)                       ctrl_o.alu_op = ALU_OR;
    else if (op_i inside {OP_AND, OP_ANDI})        ctrl_o.alu_op = ALU_AND;
    else                                           ctrl_o.alu_op = ALU_ADD;
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU control unit: state register, halt flag and next-state logic;
// control outputs come from mcc_decode and are squashed during reset/halt.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic                      CLK,
  input  logic                      Reset,
  multi_cycle_controller_if.master  bus
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (halted_q) begin
          state_d = S_ID;
        end else if (bus.op == OP_HALT) begin
          state_d  = S_ID;
          halted_d = 1'b1;
        end else if (ends_in_id(bus.op)) begin
          state_d = S_IF;
        end else if (bus.op inside {OP_BEQ, OP_BNE}) begin
          state_d = S_EXE_BR;
        end else if (bus.op inside {OP_LW, OP_SW}) begin
          state_d = S_EXE_MEM;
        end else begin
          state_d = S_EXE_ALU;
        end
      end
      S_EXE_ALU: state_d = S_WB_ALU;
      S_WB_ALU:  state_d = S_IF;
      S_EXE_BR:  state_d = S_IF;
      S_EXE_MEM: state_d = S_MEM;
      S_MEM:     state_d = (bus.op == OP_LW) ? S_WB_LW : S_IF;
      S_WB_LW:   state_d = S_IF;
      default:   state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  mcc_decode u_decode (
    .state_i (state_q),
    .op_i    (bus.op),
    .zero_i  (bus.zero),
    .ctrl_o  (ctrl_raw)
  );

  // Reset zeroes everything so an aborted instruction cannot write on the reset edge;
  // once halted, op is ignored for enables so nothing else can be committed.
  always_comb begin
    ctrl = ctrl_raw;
    if (!Reset) begin
      ctrl = '0;
    end else if (halted_q) begin
      ctrl.pc_wre     = 1'b0;
      ctrl.ir_wre     = 1'b0;
      ctrl.ins_mem_rw = 1'b0;
      ctrl.reg_wre    = 1'b0;
      ctrl.m_rd       = 1'b0;
      ctrl.m_wr       = 1'b0;
    end
  end

  assign bus.PCWre     = ctrl.pc_wre;
  assign bus.IRWre     = ctrl.ir_wre;
  assign bus.InsMemRW  = ctrl.ins_mem_rw;
  assign bus.RegWre    = ctrl.reg_wre;
  assign bus.mRD       = ctrl.m_rd;
  assign bus.mWR       = ctrl.m_wr;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ExtSel    = ctrl.ext_sel;
  assign bus.DBDataSrc = ctrl.db_data_src;
  assign bus.WrRegDSrc = ctrl.wr_reg_d_src;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.PCSrc     = ctrl.pc_src;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.state     = Reset ? state_q : S_IF;
  assign bus.halted    = Reset & halted_q;

endmodule
